// File: rtl/ext_slow_mem_arbiter.sv
// Round-robin arbiter sharing one external slow-memory slave among NMASTER masters.
// One transaction in flight; out-of-window requests get a local zero-data response and are counted.
module ext_slow_mem_arbiter #(
  parameter int          NMASTER    = 4,
  parameter logic [31:0] START_ADDR = 32'hF000_0000,
  parameter logic [31:0] SIZE       = 32'h200
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NMASTER-1:0]       m_req_i,
  input  logic [NMASTER-1:0]       m_we_i,
  input  logic [NMASTER-1:0][3:0]  m_be_i,
  input  logic [NMASTER-1:0][31:0] m_addr_i,
  input  logic [NMASTER-1:0][31:0] m_wdata_i,
  output logic [NMASTER-1:0]       m_gnt_o,
  output logic [NMASTER-1:0]       m_rvalid_o,
  output logic [NMASTER-1:0][31:0] m_rdata_o,
  output logic                     s_req_o,
  output logic                     s_we_o,
  output logic [3:0]               s_be_o,
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_wdata_o,
  input  logic                     s_gnt_i,
  input  logic                     s_rvalid_i,
  input  logic [31:0]              s_rdata_i,
  output logic                     busy_o,
  output logic [7:0]               decerr_cnt_o
);
  // state     | meaning
  // IDLE      | arbitrate, grant winner combinationally
  // WAIT_GNT  | s_req_o held until slave grants
  // WAIT_RESP | pass slave response through to owner
  // DECERR    | one-cycle local zero-data response to owner

  localparam int          IW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
  localparam logic [32:0] LO = {1'b0, START_ADDR};
  localparam logic [32:0] HI = {1'b0, START_ADDR} + {1'b0, SIZE};

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RESP, DECERR} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, r_owner;
  logic [IW-1:0]   w_winner, w_ptr_nxt;
  logic            w_found;
  logic            w_in_range;
  logic [32:0]     w_addr_ext;
  logic            r_s_req, r_s_we;
  logic [3:0]      r_s_be;
  logic [31:0]     r_s_addr, r_s_wdata;
  logic [7:0]      r_decerr_cnt;

  // Cyclic scan starting at r_ptr; first requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NMASTER; i++) begin
      if (!w_found && m_req_i[(int'(r_ptr) + i) % NMASTER]) begin
        w_found  = 1'b1;
        w_winner = IW'((int'(r_ptr) + i) % NMASTER);
      end
    end
  end

  assign w_ptr_nxt  = (w_winner == IW'(NMASTER - 1)) ? '0 : w_winner + 1'b1;
  assign w_addr_ext = {1'b0, m_addr_i[w_winner]};
  assign w_in_range = (w_addr_ext >= LO) && (w_addr_ext < HI);

  always_comb begin
    w_state_nxt = r_state;
    m_gnt_o     = '0;
    m_rvalid_o  = '0;
    m_rdata_o   = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          m_gnt_o[w_winner] = 1'b1;
          w_state_nxt       = w_in_range ? WAIT_GNT : DECERR;
        end
      end
      WAIT_GNT: begin
        if (s_gnt_i) w_state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        m_rvalid_o[r_owner] = s_rvalid_i;
        m_rdata_o[r_owner]  = s_rdata_i;
        if (s_rvalid_i) w_state_nxt = IDLE;
      end
      DECERR: begin
        m_rvalid_o[r_owner] = 1'b1;
        w_state_nxt         = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_s_req      <= 1'b0;
      r_s_we       <= 1'b0;
      r_s_be       <= '0;
      r_s_addr     <= '0;
      r_s_wdata    <= '0;
      r_decerr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_winner;
            if (w_in_range) begin
              r_s_req   <= 1'b1;
              r_s_we    <= m_we_i[w_winner];
              r_s_be    <= m_be_i[w_winner];
              r_s_addr  <= m_addr_i[w_winner];
              r_s_wdata <= m_wdata_i[w_winner];
            end else if (r_decerr_cnt != 8'hFF) begin
              r_decerr_cnt <= r_decerr_cnt + 8'd1;
            end
          end
        end
        WAIT_GNT: begin
          if (s_gnt_i) r_s_req <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign s_req_o      = r_s_req;
  assign s_we_o       = r_s_we;
  assign s_be_o       = r_s_be;
  assign s_addr_o     = r_s_addr;
  assign s_wdata_o    = r_s_wdata;
  assign busy_o       = (r_state != IDLE);
  assign decerr_cnt_o = r_decerr_cnt;

endmodule

// File: tb/tb_ext_slow_mem_arbiter.sv
// Self-checking bench for ext_slow_mem_arbiter: vector table, scoreboard of expected
// responses, and hand sequences for fairness, stall, reset and counter saturation.
module tb_ext_slow_mem_arbiter;
  localparam int NM = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [NM-1:0]       m_req_i, m_we_i;
  logic [NM-1:0][3:0]  m_be_i;
  logic [NM-1:0][31:0] m_addr_i, m_wdata_i;
  logic [NM-1:0]       m_gnt_o, m_rvalid_o;
  logic [NM-1:0][31:0] m_rdata_o;
  logic                s_req_o, s_we_o;
  logic [3:0]          s_be_o;
  logic [31:0]         s_addr_o, s_wdata_o;
  logic                s_gnt_i, s_rvalid_i;
  logic [31:0]         s_rdata_i;
  logic                busy_o;
  logic [7:0]          decerr_cnt_o;

  ext_slow_mem_arbiter #(.NMASTER(NM), .START_ADDR(32'hF000_0000), .SIZE(32'h200)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_be_i(m_be_i), .m_addr_i(m_addr_i),
    .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .busy_o(busy_o), .decerr_cnt_o(decerr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          m;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    int          stall;
    logic        err;
  } vec_t;

  typedef struct {
    int          m;
    logic [31:0] d;
  } exp_t;

  vec_t   vecs[7];
  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     exp_cnt  = 0;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    logic [NM-1:0][31:0] ed;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: response %0h with empty scoreboard, expected none", nm, m_rvalid_o);
    end else begin
      e = sb.pop_front();
      ed = '0;
      ed[e.m] = e.d;
      chk({nm, "_rvalid"}, m_rvalid_o, 128'(1) << e.m);
      chk({nm, "_rdata"}, m_rdata_o, ed);
    end
  endtask

  // Entered at posedge+2 of the grant cycle; returns at posedge+2 with DUT idle.
  task automatic do_txn(input vec_t v);
    m_req_i = '0;
    m_req_i[v.m]   = 1'b1;
    m_we_i[v.m]    = v.we;
    m_be_i[v.m]    = v.be;
    m_addr_i[v.m]  = v.addr;
    m_wdata_i[v.m] = v.wdata;
    #1;
    chk("txn_gnt", m_gnt_o, 128'(1) << v.m);
    sb.push_back('{v.m, v.err ? 32'h0 : v.sdata});
    tick();
    m_req_i = '0;
    #1;
    chk("txn_gnt_off", m_gnt_o, 0);
    if (v.err) begin
      chk("err_no_sreq", s_req_o, 0);
      pop_check("err");
      if (exp_cnt != 255) exp_cnt++;
      chk("err_cnt", decerr_cnt_o, exp_cnt);
      tick();
      #1;
      chk("err_idle", {s_req_o, busy_o, m_rvalid_o}, 0);
    end else begin
      chk("slv_fields", {s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o},
          {1'b1, v.we, v.be, v.addr, v.wdata});
      for (int k = 0; k < v.stall; k++) begin
        m_req_i    = ~(NM'(1) << v.m);
        s_rvalid_i = 1'b1;
        #1;
        chk("stall_no_gnt", m_gnt_o, 0);
        chk("stall_no_rvalid", m_rvalid_o, 0);
        chk("stall_hold", {s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o},
            {1'b1, v.we, v.be, v.addr, v.wdata});
        tick();
      end
      m_req_i    = '0;
      s_rvalid_i = 1'b0;
      s_gnt_i    = 1'b1;
      #1;
      chk("wgnt_no_rvalid", m_rvalid_o, 0);
      tick();
      s_gnt_i    = 1'b0;
      s_rvalid_i = 1'b1;
      s_rdata_i  = v.sdata;
      #1;
      chk("resp_sreq_low", s_req_o, 0);
      pop_check("resp");
      tick();
      s_rvalid_i = 1'b0;
      s_rdata_i  = '0;
      #1;
      chk("resp_idle", busy_o, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int order[5];
    int gi, last_rv, ngr;

    vecs[0] = '{2, 1'b0, 4'hF, 32'hF000_0010, 32'h0,         32'hA5A5_1234, 0, 1'b0};
    vecs[1] = '{1, 1'b1, 4'hF, 32'hF000_0200, 32'hDEAD_BEEF, 32'h0,         0, 1'b1};
    vecs[2] = '{0, 1'b1, 4'h3, 32'hF000_0000, 32'h1234_5678, 32'h0BAD_F00D, 5, 1'b0};
    vecs[3] = '{3, 1'b0, 4'hF, 32'hF000_01FC, 32'h0,         32'h7777_8888, 1, 1'b0};
    vecs[4] = '{0, 1'b0, 4'hF, 32'hEFFF_FFFC, 32'h0,         32'h0,         0, 1'b1};
    vecs[5] = '{2, 1'b1, 4'h1, 32'hFFFF_FFFF, 32'h5555_AAAA, 32'h0,         0, 1'b1};
    vecs[6] = '{1, 1'b0, 4'hC, 32'hF000_0100, 32'h0,         32'h1357_9BDF, 2, 1'b0};
    order   = '{0, 1, 2, 3, 0};

    rst_ni = 1'b0;
    m_req_i = '0; m_we_i = '0; m_be_i = '0; m_addr_i = '0; m_wdata_i = '0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
    #3;
    chk("reset_state", {s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o, m_gnt_o, m_rvalid_o,
                        busy_o, decerr_cnt_o}, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) do_txn(vecs[i]);

    // Reset while waiting for the slave response.
    m_req_i = 4'b0001; m_we_i = '0; m_addr_i[0] = 32'hF000_0040;
    #1;
    chk("rst_pre_gnt", m_gnt_o, 4'b0001);
    tick();
    m_req_i = '0;
    s_gnt_i = 1'b1;
    tick();
    s_gnt_i = 1'b0;
    #1;
    chk("rst_in_wresp", {busy_o, s_req_o}, 2'b10);
    rst_ni = 1'b0;
    #1;
    chk("rst_async", {s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o, m_gnt_o, m_rvalid_o,
                      busy_o, decerr_cnt_o}, 0);
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hBAAD_BAAD;
    #1;
    chk("rst_no_rvalid", {m_rvalid_o, m_rdata_o}, 0);
    exp_cnt = 0;
    tick();
    rst_ni = 1'b1;
    #1;
    chk("rst_stale_resp", {m_rvalid_o, m_rdata_o, busy_o}, 0);
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;
    tick();
    do_txn('{3, 1'b0, 4'hF, 32'hF000_0080, 32'h0, 32'h3333_CAFE, 0, 1'b0});

    // Fairness: everyone requests, slave answers immediately.
    for (int i = 0; i < NM; i++) m_addr_i[i] = 32'hF000_0000 + 32'(i * 4);
    m_we_i = '0; m_req_i = '1;
    s_gnt_i = 1'b1; s_rvalid_i = 1'b1; s_rdata_i = 32'h600D_0000;
    gi = 0; last_rv = -10;
    for (int c = 0; c < 40 && gi < 5; c++) begin
      #1;
      if (m_gnt_o != 0) begin
        chk("fair_gnt", m_gnt_o, 128'(1) << order[gi]);
        if (gi > 0) chk("fair_gap", c, last_rv + 1);
        sb.push_back('{order[gi], 32'h600D_0000});
        gi++;
      end
      if (m_rvalid_o != 0) begin
        last_rv = c;
        pop_check("fair");
      end
      tick();
    end
    m_req_i = '0;
    for (int c = 0; c < 10 && busy_o; c++) begin
      #1;
      if (m_rvalid_o != 0) pop_check("fair_tail");
      tick();
    end
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
    chk("fair_grants", gi, 5);
    chk("fair_sb_empty", sb.size(), 0);
    chk("fair_no_sreq", s_req_o, 0);

    // Decode-error counter saturation.
    for (int i = 0; i < NM; i++) m_addr_i[i] = 32'h1000_0000 + 32'(i);
    m_req_i = '1;
    ngr = 0;
    for (int c = 0; c < 1000 && ngr < 300; c++) begin
      #1;
      if (m_gnt_o != 0) begin
        ngr++;
        if (exp_cnt != 255) exp_cnt++;
      end
      if (s_req_o) chk("sat_no_sreq", s_req_o, 0);
      tick();
    end
    m_req_i = '0;
    tick();
    #1;
    chk("sat_grants", ngr, 300);
    chk("sat_cnt", decerr_cnt_o, exp_cnt);
    chk("sat_idle", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
